buffer_mem: RTL and testbench

BUFFER_MEM -- requirements
Module: buffer_mem

---
 rtl/buffer_mem_if.sv | 47 ++++
 rtl/buffer_mem.sv | 131 +++++++++++++
 tb/tb_buffer_mem.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : buffer_mem_if
// Description : Bus bundle for buffer_mem. Carries the core (single-port SRAM
//               style, active-low enables) access port and the host
//               request/grant port with its valid/ready read-response channel.
//               master : the side issuing core/host accesses
//               slave  : the buffer_mem instance
// Revision    : 1.0 - initial release
// ============================================================================
interface buffer_mem_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 256
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // core port
  logic                        cenb_i;
  logic                        wenb_i;
  logic [AW-1:0]               addr_i;
  logic [LANES-1:0][WIDTH-1:0] data_i;
  logic [LANES-1:0][WIDTH-1:0] data_o;

  // host port
  logic                        host_req_i;
  logic                        host_we_i;
  logic [AW-1:0]               host_addr_i;
  logic [LANES-1:0][WIDTH-1:0] host_wdata_i;
  logic                        host_gnt_o;
  logic                        host_rvalid_o;
  logic [LANES-1:0][WIDTH-1:0] host_rdata_o;
  logic                        host_rready_i;

  modport master (
    output cenb_i, wenb_i, addr_i, data_i,
    output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_rready_i,
    input  data_o, host_gnt_o, host_rvalid_o, host_rdata_o
  );

  modport slave (
    input  cenb_i, wenb_i, addr_i, data_i,
    input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_rready_i,
    output data_o, host_gnt_o, host_rvalid_o, host_rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : buffer_mem
// Description : DEPTH x (LANES*WIDTH) buffer memory with a priority core port,
//               an arbitrated host port (read responses with valid/ready
//               back-pressure) and a background zero-fill engine.
// Ports       : clk_i   - clock, rising edge
//               rstn_i  - asynchronous active-low reset
//               bus     - buffer_mem_if.slave (core + host ports)
//               clear_i - pulse to start zero-fill of the whole array
//               busy_o  - zero-fill in progress
//               err_o   - sticky: core access attempted during zero-fill
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_mem #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int DEPTH = 256
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  buffer_mem_if.slave       bus,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0]    c_IDLE  = 1'b0;
  localparam logic [0:0]    c_CLEAR = 1'b1;
  localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

  logic [0:0]                  r_state;
  logic [AW-1:0]               r_cnt;
  logic [LANES-1:0][WIDTH-1:0] r_mem [DEPTH];
  logic [LANES-1:0][WIDTH-1:0] r_data;
  logic [LANES-1:0][WIDTH-1:0] r_rdata;
  logic                        r_rvalid;
  logic                        r_err;

  logic w_idle;
  logic w_core_wr;
  logic w_core_rd;
  logic w_rd_stall;
  logic w_gnt;
  logic w_host_wr;
  logic w_host_rd;

  assign w_idle     = (r_state == c_IDLE);
  assign w_core_wr  = w_idle & ~bus.cenb_i & ~bus.wenb_i;
  assign w_core_rd  = w_idle & ~bus.cenb_i &  bus.wenb_i;
  // A new host read cannot be accepted while the previous response sits
  // un-consumed; host writes are still allowed through.
  assign w_rd_stall = ~bus.host_we_i & r_rvalid & ~bus.host_rready_i;
  // Gating with rstn_i keeps the grant low for the whole reset window.
  assign w_gnt      = rstn_i & bus.host_req_i & bus.cenb_i & w_idle & ~w_rd_stall;
  assign w_host_wr  = w_gnt &  bus.host_we_i;
  assign w_host_rd  = w_gnt & ~bus.host_we_i;

  // FSM and fill counter
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_cnt <= '0;
          if (clear_i) r_state <= c_CLEAR;
        end
        c_CLEAR: begin
          if (r_cnt == c_LAST) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array, intentionally not reset. Only one writer is possible per
  // cycle: the fill engine owns the array outside IDLE, and the host grant
  // already excludes any core access.
  always_ff @(posedge clk_i) begin
    if (!w_idle) begin
      r_mem[r_cnt] <= '0;
    end else if (w_core_wr) begin
      r_mem[bus.addr_i] <= bus.data_i;
    end else if (w_host_wr) begin
      r_mem[bus.host_addr_i] <= bus.host_wdata_i;
    end
  end

  // Read registers and sticky error
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_data   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_core_rd) r_data <= r_mem[bus.addr_i];

      // Response register keeps ticking through CLEAR so an outstanding
      // response still drains.
      if (w_host_rd) begin
        r_rdata  <= r_mem[bus.host_addr_i];
        r_rvalid <= 1'b1;
      end else if (bus.host_rready_i) begin
        r_rdata  <= '0;
        r_rvalid <= 1'b0;
      end

      if (!w_idle && !bus.cenb_i) r_err <= 1'b1;
    end
  end

  assign bus.data_o        = r_data;
  assign bus.host_gnt_o    = w_gnt;
  assign bus.host_rvalid_o = r_rvalid;
  assign bus.host_rdata_o  = r_rdata;
  assign busy_o            = ~w_idle;
  assign err_o             = r_err;
endmodule
`default_nettype wire

// File: tb/tb_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_mem
// Description : Self-checking bench for buffer_mem. A reference word array
//               tracks the expected contents; expected read data is queued
//               when a read is issued and compared when the DUT returns it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_mem;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 256;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic clear = 1'b0;
  logic busy;
  logic err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] core_q [$];
  logic [31:0] host_q [$];
  logic [31:0] last_core = '0;
  logic        clr_active = 1'b0;

  buffer_mem_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) b ();

  buffer_mem #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .bus     (b.slave),
    .clear_i (clear),
    .busy_o  (busy),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the current inputs: scoreboard bookkeeping before
  // the edge, core read-data compare after it.
  task automatic step();
    logic        core_rd;
    logic [31:0] e;
    #1;
    if (b.host_rvalid_o && b.host_rready_i) begin
      chk("host_resp_expected", 32'(host_q.size() != 0), 32'd1);
      if (host_q.size() != 0) begin
        e = host_q.pop_front();
        chk("host_rdata", b.host_rdata_o, e);
      end
    end
    if (b.host_gnt_o && !b.host_we_i) host_q.push_back(model[b.host_addr_i]);
    core_rd = !clr_active && !b.cenb_i && b.wenb_i;
    if (core_rd) core_q.push_back(model[b.addr_i]);
    if (!clr_active && !b.cenb_i && !b.wenb_i) model[b.addr_i] = b.data_i;
    else if (b.host_gnt_o && b.host_we_i) model[b.host_addr_i] = b.host_wdata_i;
    @(posedge clk);
    #1;
    if (core_rd) begin
      e = core_q.pop_front();
      last_core = e;
      chk("core_rdata", b.data_o, e);
    end
  endtask

  task automatic core_write(input logic [7:0] a, input logic [31:0] d);
    b.cenb_i = 1'b0; b.wenb_i = 1'b0; b.addr_i = a; b.data_i = d;
    step();
    b.cenb_i = 1'b1; b.wenb_i = 1'b1;
  endtask

  task automatic core_read(input logic [7:0] a);
    b.cenb_i = 1'b0; b.wenb_i = 1'b1; b.addr_i = a;
    step();
    b.cenb_i = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    b.host_req_i = 1'b1; b.host_we_i = 1'b1; b.host_addr_i = a; b.host_wdata_i = d;
    #1 chk("host_wr_gnt", 32'(b.host_gnt_o), 32'd1);
    step();
    b.host_req_i = 1'b0; b.host_we_i = 1'b0;
  endtask

  // Pulse clear_i; returns with clr_active set and the first busy cycle seen.
  task automatic start_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    clr_active = 1'b1;
  endtask

  task automatic finish_clear(input int already);
    int n;
    n = already;
    while (busy && n < 1000) begin
      n++;
      step();
    end
    chk("busy_cycles", n, DEPTH);
    clr_active = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    b.cenb_i = 1'b1; b.wenb_i = 1'b1; b.addr_i = '0; b.data_i = '0;
    b.host_req_i = 1'b1; b.host_we_i = 1'b0; b.host_addr_i = '0;
    b.host_wdata_i = '0; b.host_rready_i = 1'b1;

    // Reset state, with a host request pending to confirm no grant
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_o", b.data_o, 32'd0);
    chk("rst_rdata", b.host_rdata_o, 32'd0);
    chk("rst_rvalid", 32'(b.host_rvalid_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_gnt", 32'(b.host_gnt_o), 32'd0);
    b.host_req_i = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Initial zero-fill gives known contents
    start_clear();
    finish_clear(0);

    // Core write then read-back, hold through idle cycles
    core_write(8'd5, 32'hAABBCCDD);
    core_read(8'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("data_o_hold", b.data_o, 32'hAABBCCDD);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(10, 190));
      core_write(a, $urandom);
      host_write(8'(a + 8'd1), $urandom);
      core_read(a);
      core_read(8'(a + 8'd1));
    end

    // Core priority over a simultaneous host read
    b.cenb_i = 1'b0; b.wenb_i = 1'b1; b.addr_i = 8'd5;
    b.host_req_i = 1'b1; b.host_we_i = 1'b0; b.host_addr_i = 8'd5;
    #1 chk("gnt_core_prio", 32'(b.host_gnt_o), 32'd0);
    step();
    b.cenb_i = 1'b1;
    #1 chk("gnt_after_core", 32'(b.host_gnt_o), 32'd1);
    step();
    b.host_req_i = 1'b0;
    step();

    // Host reads 1,2,3 with a stalled response and a write during the stall
    host_write(8'd1, 32'h11111111);
    host_write(8'd2, 32'h22222222);
    host_write(8'd3, 32'h33333333);
    b.host_rready_i = 1'b0;
    b.host_req_i = 1'b1; b.host_we_i = 1'b0; b.host_addr_i = 8'd1;
    #1 chk("rd1_gnt", 32'(b.host_gnt_o), 32'd1);
    step();
    b.host_addr_i = 8'd2;
    #1 chk("rd2_stalled", 32'(b.host_gnt_o), 32'd0);
    step();
    chk("rvalid_held", 32'(b.host_rvalid_o), 32'd1);
    b.host_we_i = 1'b1; b.host_addr_i = 8'd9; b.host_wdata_i = 32'h99999999;
    #1 chk("wr_in_stall_gnt", 32'(b.host_gnt_o), 32'd1);
    step();
    b.host_we_i = 1'b0; b.host_addr_i = 8'd2; b.host_rready_i = 1'b1;
    #1 chk("rd2_gnt", 32'(b.host_gnt_o), 32'd1);
    step();
    b.host_addr_i = 8'd3;
    step();
    b.host_req_i = 1'b0;
    step();
    chk("rvalid_drained", 32'(b.host_rvalid_o), 32'd0);
    chk("host_q_empty", 32'(host_q.size()), 32'd0);
    core_read(8'd9);

    // Zero-fill with a core write and a core read attempted inside it
    core_write(8'd0, 32'h01010101);
    core_write(8'd128, 32'h80808080);
    core_write(8'd255, 32'hFFFF0000);
    core_write(8'd7, 32'h07070707);
    core_read(8'd7);
    start_clear();
    b.cenb_i = 1'b0; b.wenb_i = 1'b0; b.addr_i = 8'd7; b.data_i = 32'hDEADBEEF;
    step();
    b.wenb_i = 1'b1; b.addr_i = 8'd128;
    step();
    b.cenb_i = 1'b1;
    chk("data_o_hold_clear", b.data_o, last_core);
    chk("err_set", 32'(err), 32'd1);
    chk("gnt_in_clear", 32'(b.host_gnt_o), 32'd0);
    finish_clear(2);
    core_read(8'd0);
    core_read(8'd128);
    core_read(8'd255);
    core_read(8'd7);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset during a fill aborts it; untouched words keep their data
    core_write(8'd200, 32'h12345678);
    start_clear();
    for (int i = 0; i < 9; i++) step();
    rstn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    step();
    rstn = 1'b1;
    clr_active = 1'b0;
    step();
    chk("busy_after_abort", 32'(busy), 32'd0);
    core_read(8'd200);
    chk("core_q_empty", 32'(core_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
